// File: rtl/lc3b_types.sv
// lc3b_types: shared LC-3b word/opcode types plus branch-predictor counter type and constants
package lc3b_types;
  typedef logic [15:0] lc3b_word;
  typedef enum logic [3:0] {
    op_br   = 4'b0000,
    op_add  = 4'b0001,
    op_ldb  = 4'b0010,
    op_stb  = 4'b0011,
    op_jsr  = 4'b0100,
    op_and  = 4'b0101,
    op_ldw  = 4'b0110,
    op_stw  = 4'b0111,
    op_rti  = 4'b1000,
    op_not  = 4'b1001,
    op_ldi  = 4'b1010,
    op_sti  = 4'b1011,
    op_jmp  = 4'b1100,
    op_shf  = 4'b1101,
    op_lea  = 4'b1110,
    op_trap = 4'b1111
  } lc3b_opcode;
  typedef logic [1:0] lc3b_bp_ctr;
  localparam lc3b_bp_ctr BP_CTR_RESET = 2'b01;
  localparam lc3b_bp_ctr BP_CTR_MAX   = 2'b11;
  localparam lc3b_bp_ctr BP_CTR_MIN   = 2'b00;
endpackage

// File: rtl/sat_counter2.sv
// sat_counter2: 2-bit saturating up/down counter (en, inc=up/down), sync reset to weakly not-taken
module sat_counter2
  import lc3b_types::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic       inc,
  output lc3b_bp_ctr ctr
);
  lc3b_bp_ctr ctr_q, ctr_d;
  always_comb begin
    ctr_d = !en ? ctr_q :
            inc ? (ctr_q == BP_CTR_MAX ? ctr_q : ctr_q + 2'd1) :
                  (ctr_q == BP_CTR_MIN ? ctr_q : ctr_q - 2'd1);
  end
  always_ff @(posedge clk) begin
    if (reset) ctr_q <= BP_CTR_RESET;
    else ctr_q <= ctr_d;
  end
  assign ctr = ctr_q;
endmodule

// File: rtl/branch_predictor.sv
// branch_predictor: gshare predictor (fetch_pc/opcode -> prediction/pred_idx), trained by upd_*, with saturating stat counters
module branch_predictor
  import lc3b_types::*;
#(
  parameter int IDX_BITS  = 3,
  parameter int HIST_BITS = 3,
  parameter int STAT_BITS = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [15:0]          fetch_pc,
  input  logic [3:0]           fetch_opcode,
  output logic                 prediction,
  output logic [IDX_BITS-1:0]  pred_idx,
  input  logic                 upd_valid,
  input  logic [IDX_BITS-1:0]  upd_idx,
  input  logic                 upd_taken,
  input  logic                 upd_mispred,
  output logic [STAT_BITS-1:0] stat_branches,
  output logic [STAT_BITS-1:0] stat_mispreds
);
  localparam int ENTRIES = 1 << IDX_BITS;
  lc3b_bp_ctr ctr [ENTRIES];
  logic [HIST_BITS-1:0] ghr_q, ghr_d;
  logic [STAT_BITS-1:0] br_q, br_d, mis_q, mis_d;
  logic unused_pc;
  for (genvar i = 0; i < ENTRIES; i++) begin : g_ctr
    sat_counter2 u_ctr (
      .clk   (clk),
      .reset (reset),
      .en    (upd_valid && upd_idx == IDX_BITS'(i)),
      .inc   (upd_taken),
      .ctr   (ctr[i])
    );
  end
  assign unused_pc = ^{fetch_pc[15:IDX_BITS+1], fetch_pc[0]};
  always_comb begin
    pred_idx   = fetch_pc[IDX_BITS:1] ^ IDX_BITS'(ghr_q);
    prediction = ctr[pred_idx][1] && fetch_opcode == op_br;
    ghr_d      = upd_valid ? {ghr_q[HIST_BITS-2:0], upd_taken} : ghr_q;
    br_d       = upd_valid && !(&br_q) ? br_q + STAT_BITS'(1) : br_q;
    mis_d      = upd_valid && upd_mispred && !(&mis_q) ? mis_q + STAT_BITS'(1) : mis_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      ghr_q <= '0;
      br_q  <= '0;
      mis_q <= '0;
    end else begin
      ghr_q <= ghr_d;
      br_q  <= br_d;
      mis_q <= mis_d;
    end
  end
  assign stat_branches = br_q;
  assign stat_mispreds = mis_q;
endmodule

// File: tb/tb_branch_predictor.sv
// tb_branch_predictor: scoreboard bench for branch_predictor with directed, hand-computed vectors
module tb_branch_predictor;
  import lc3b_types::*;
  typedef struct {
    int          sel;
    logic [15:0] exp;
    string       name;
  } exp_t;
  logic        clk = 0;
  logic        reset = 0;
  logic [15:0] fetch_pc = '0;
  logic [3:0]  fetch_opcode = op_br;
  logic        prediction;
  logic [2:0]  pred_idx;
  logic        upd_valid = 0;
  logic [2:0]  upd_idx = '0;
  logic        upd_taken = 0;
  logic        upd_mispred = 0;
  logic [3:0]  stat_branches, stat_mispreds;
  exp_t        sb [$];
  int          passed = 0;
  int          total = 0;
  branch_predictor #(.IDX_BITS(3), .HIST_BITS(3), .STAT_BITS(4)) dut (
    .clk           (clk),
    .reset         (reset),
    .fetch_pc      (fetch_pc),
    .fetch_opcode  (fetch_opcode),
    .prediction    (prediction),
    .pred_idx      (pred_idx),
    .upd_valid     (upd_valid),
    .upd_idx       (upd_idx),
    .upd_taken     (upd_taken),
    .upd_mispred   (upd_mispred),
    .stat_branches (stat_branches),
    .stat_mispreds (stat_mispreds)
  );
  always #5 clk = ~clk;
  always @(negedge clk) begin
    while (sb.size() > 0) begin
      exp_t e;
      logic [15:0] act;
      e = sb.pop_front();
      act = e.sel == 0 ? {15'd0, prediction} :
            e.sel == 1 ? {13'd0, pred_idx} :
            e.sel == 2 ? {12'd0, stat_branches} : {12'd0, stat_mispreds};
      total++;
      if (act === e.exp) passed++;
      else $display("FAIL %s: got %0h expected %0h", e.name, act, e.exp);
    end
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input int sel, input logic [15:0] exp, input string name);
    sb.push_back('{sel, exp, name});
  endtask
  task automatic upd(input logic [2:0] idx, input logic taken, input logic mis);
    upd_valid = 1; upd_idx = idx; upd_taken = taken; upd_mispred = mis;
    tick();
    upd_valid = 0;
  endtask
  task automatic do_reset(input logic with_upd);
    reset = 1; upd_valid = with_upd; upd_idx = 3'd7; upd_taken = 1; upd_mispred = 1;
    tick();
    reset = 0; upd_valid = 0;
  endtask
  task automatic fetch(input logic [15:0] pc, input logic [3:0] op, input logic [2:0] idx, input logic p, input string name);
    fetch_pc = pc; fetch_opcode = op;
    chk(1, {13'd0, idx}, {name, "_idx"});
    chk(0, {15'd0, p}, {name, "_pred"});
  endtask
  task automatic stats(input logic [3:0] b, input logic [3:0] m, input string name);
    chk(2, {12'd0, b}, {name, "_branches"});
    chk(3, {12'd0, m}, {name, "_mispreds"});
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end
  initial begin
    do_reset(1);
    fetch(16'h0004, op_br, 3'd2, 0, "reset_read");
    stats(0, 0, "reset");
    tick();
    upd(2, 1, 0); upd(2, 1, 0);
    upd(5, 0, 0); upd(5, 0, 0); upd(5, 0, 0);
    fetch(16'h0004, op_br, 3'd2, 1, "trained");
    stats(5, 0, "trained");
    tick();
    upd(2, 1, 0);
    upd(2, 0, 0);
    fetch(16'h0000, op_br, 3'd2, 1, "sat_hi");
    tick();
    upd(2, 0, 0);
    fetch(16'h000C, op_br, 3'd2, 0, "sat_weak");
    stats(8, 0, "train_end");
    tick();
    do_reset(0);
    upd(0, 1, 0);
    fetch(16'h0004, op_br, 3'd3, 0, "hist1");
    tick();
    upd(0, 1, 0); upd(0, 1, 0); upd(0, 1, 0);
    fetch(16'h0004, op_br, 3'd5, 0, "hist7");
    stats(4, 0, "hist");
    tick();
    fetch(16'h000E, op_br, 3'd0, 1, "hist_ctr0");
    tick();
    do_reset(0);
    fetch(16'h0006, op_br, 3'd3, 0, "collide_now");
    upd_valid = 1; upd_idx = 3; upd_taken = 1; upd_mispred = 1;
    tick();
    upd_valid = 0;
    fetch(16'h0004, op_br, 3'd3, 1, "collide_next");
    stats(1, 1, "collide");
    tick();
    upd(3, 1, 0);
    fetch(16'h0000, op_br, 3'd3, 1, "nonbr_br");
    tick();
    fetch(16'h0000, op_add, 3'd3, 0, "nonbr_add");
    tick();
    do_reset(0);
    for (int i = 0; i < 20; i++) begin
      upd(7, 1, 1);
      if (i == 13) begin
        stats(14, 14, "stat14");
        tick();
      end
    end
    stats(15, 15, "stat_sat");
    fetch(16'h0000, op_br, 3'd7, 1, "stat_ctr7");
    tick();
    do_reset(1);
    stats(0, 0, "reset_prio");
    fetch(16'h000E, op_br, 3'd7, 0, "reset_prio");
    tick();
    tick();
    if (sb.size() != 0) begin
      total += sb.size();
      $display("FAIL scoreboard: got %0d unchecked expected 0", sb.size());
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
